// File: rtl/clock_phase_generator.sv
// clock_phase_generator
// Divides the master oscillator into the P/Q/R phase-pair flops that feed the
// W/X/Y/Z clock drivers. It also generates the driver enable (BOP) and the
// bit-time / computer-phase counters used for downstream timing decode.
//
//   state | meaning (P,Q,R)
//   ------+------------------------------------------------------------
//   ST_Z  | 0,0,0  reset state; the edge leaving Z is the bit-time boundary
//   ST_W  | 1,0,1  first quarter of a bit time (decode P & R)
//   ST_X  | 0,1,1  second quarter (decode ~P & Q)
//   ST_Y  | 1,1,0  third quarter (decode P & ~R)
//
// The state code is the (P,Q,R) triple itself, so every phase output comes
// straight from a flop. P toggles every edge and (R,Q) forms a 2-bit Johnson
// counter, so exactly one driver decode is true per state.
module clock_phase_generator #(
   parameter int BIT_TIMES      = 28,
   parameter int STARTUP_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       HALT,
   output logic       CGPP,
   output logic       CGPPN,
   output logic       CGQP,
   output logic       CGQPN,
   output logic       CGRP,
   output logic       CGRPN,
   output logic       BOP,
   output logic [4:0] BT,
   output logic [1:0] PH,
   output logic       BTZ
);

   typedef enum logic [2:0] {
      ST_Z = 3'b000,
      ST_W = 3'b101,
      ST_X = 3'b011,
      ST_Y = 3'b110
   } phase_e;

   localparam logic [4:0] BT_LAST    = 5'(BIT_TIMES - 1);
   localparam logic [7:0] STARTUP_TH = 8'(STARTUP_CYCLES);

   phase_e      phase_q, phase_d;
   logic [7:0]  startup_q, startup_d;
   logic        bop_q, bop_d;
   logic [4:0]  bt_q, bt_d;
   logic [1:0]  ph_q, ph_d;
   logic        z_edge;

   // State register: phase flops, startup counter, driver enable and counters.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         phase_q   <= ST_Z;
         startup_q <= 8'd0;
         bop_q     <= 1'b0;
         bt_q      <= 5'd0;
         ph_q      <= 2'd0;
      end else begin
         phase_q   <= phase_d;
         startup_q <= startup_d;
         bop_q     <= bop_d;
         bt_q      <= bt_d;
         ph_q      <= ph_d;
      end
   end

   // Next-state: free-running phase ring, saturating startup count, and the
   // BOP/BT/PH updates that happen only on the edge leaving Z.
   always_comb begin
      phase_d   = ST_Z;
      startup_d = startup_q;
      bop_d     = bop_q;
      bt_d      = bt_q;
      ph_d      = ph_q;
      z_edge    = (phase_q == ST_Z);

      case (phase_q)
         ST_Z:    phase_d = ST_W;
         ST_W:    phase_d = ST_X;
         ST_X:    phase_d = ST_Y;
         default: phase_d = ST_Z;
      endcase

      if (startup_q != 8'hFF) begin
         startup_d = startup_q + 8'd1;
      end

      if (z_edge) begin
         if (bop_q) begin
            // The bit time still advances on the halting edge, so BT names
            // the next bit time to execute while halted.
            if (bt_q == BT_LAST) begin
               bt_d = 5'd0;
               ph_d = ph_q + 2'd1;
            end else begin
               bt_d = bt_q + 5'd1;
            end
            if (HALT) begin
               bop_d = 1'b0;
            end
         end else if ((startup_q >= STARTUP_TH) && !HALT) begin
            bop_d = 1'b1;
         end
      end
   end

   assign CGPP  = phase_q[2];
   assign CGQP  = phase_q[1];
   assign CGRP  = phase_q[0];
   assign CGPPN = ~phase_q[2];
   assign CGQPN = ~phase_q[1];
   assign CGRPN = ~phase_q[0];
   assign BOP   = bop_q;
   assign BT    = bt_q;
   assign PH    = ph_q;
   assign BTZ   = bop_q & (bt_q == 5'd0);

endmodule
